bus_arbiter4: RTL and testbench

Round-robin arbiter that drives the select and enable inputs of the four-way tri-state bus selector. Four masters request the shared bus. The arbiter grants one master at a time and bounds each tenure with a burst limit. It inserts one idle turnaround cycle between owners so that no two drivers ever overlap on the tri-state net.

---
 rtl/bus_arb_pkg.sv | 23 ++
 rtl/bus_arbiter4_rr_pick4.sv | 27 ++
 rtl/bus_arbiter4.sv | 112 +++++++++++
 tb/tb_bus_arbiter4.sv | 132 +++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the four-master round-robin bus arbiter.
package bus_arb_pkg;

  localparam int unsigned NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } arb_state_t;

  // Master index, s[1] is the MSB to match the downstream selector ordering.
  typedef logic [1:2] idx_t;

  // One-hot decode of a master index.
  function automatic logic [NUM_REQ-1:0] onehot(input idx_t i);
    logic [NUM_REQ-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// Combinational round-robin picker: first requester after 'last', ascending with wrap.
module rr_pick4
  import bus_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  idx_t               last,
  output logic               valid,
  output idx_t               idx
);

  idx_t cand;

  // Scan last+1, last+2, last+3, last (wrap) and keep the first hit.
  always_comb begin
    valid = 1'b0;
    idx   = last;
    cand  = last;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = last + idx_t'(k);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin bus arbiter with burst limit and one-cycle turnaround between owners.
module bus_arbiter4
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output idx_t               s,
  output logic               enable,
  output logic               busy
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  arb_state_t         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  idx_t               last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  idx_t               s_q, s_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;

  logic pick_valid;
  idx_t pick_idx;

  rr_pick4 u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state, burst count, owner tracking and next output values.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    last_d   = last_q;
    grant_d  = '0;
    s_d      = s_q;
    enable_d = 1'b0;
    busy_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          count_d = CW'(1);
          last_d  = pick_idx;
        end
      end
      GRANT: begin
        if (!req[last_q] || (count_q == CW'(MAX_BURST))) begin
          state_d = TURN;
          count_d = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      TURN: begin
        if (pick_valid) begin
          state_d = GRANT;
          count_d = CW'(1);
          last_d  = pick_idx;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    // Outputs follow the next state so they line up with the registered state.
    enable_d = (state_d == GRANT);
    busy_d   = (state_d != IDLE);
    if (state_d == GRANT) begin
      grant_d = onehot(last_d);
      s_d     = last_d;
    end
  end

  // State, counter, owner and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      last_q   <= idx_t'(3);
      grant_q  <= '0;
      s_q      <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      s_q      <= s_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
    end
  end

  assign grant  = grant_q;
  assign s      = s_q;
  assign enable = enable_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4: a cycle table at MAX_BURST=4 plus a round-robin run at MAX_BURST=2.
module tb_bus_arbiter4;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] s;
    logic       en;
    logic       busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst4, rst2;
  logic [3:0] req4, req2;
  logic [3:0] grant4, grant2;
  logic [1:2] s4, s2;
  logic       en4, en2, busy4, busy2;

  int n_cmp = 0;
  int n_err = 0;
  int row   = 0;
  int nv    = 0;
  vec_t tv[64];

  always #5 clk = ~clk;

  bus_arbiter4 #(.MAX_BURST(4)) dut4 (
    .clk(clk), .rst(rst4), .req(req4),
    .grant(grant4), .s(s4), .enable(en4), .busy(busy4)
  );

  bus_arbiter4 #(.MAX_BURST(2)) dut2 (
    .clk(clk), .rst(rst2), .req(req2),
    .grant(grant2), .s(s2), .enable(en2), .busy(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                     input logic [1:0] sv, input logic e, input logic b);
    tv[nv] = '{rst: r, req: rq, grant: g, s: sv, en: e, busy: b};
    nv++;
  endtask

  initial begin
    logic [1:0] s_act;
    logic [3:0] g_exp;
    int         owner;
    int         phase;

    rst4 = 1'b1; req4 = 4'b0000;
    rst2 = 1'b1; req2 = 4'b0000;

    // Reset held with all requests high.
    add(1, 4'b1111, 4'b0000, 2'b00, 0, 0);
    add(1, 4'b1111, 4'b0000, 2'b00, 0, 0);
    add(1, 4'b1111, 4'b0000, 2'b00, 0, 0);
    add(0, 4'b1111, 4'b0001, 2'b00, 1, 1);   // master 0 first after reset
    // Sole requester 2: four granted cycles, one turnaround, repeat.
    add(0, 4'b0100, 4'b0000, 2'b00, 0, 1);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) add(0, 4'b0100, 4'b0100, 2'b10, 1, 1);
      add(0, 4'b0100, 4'b0000, 2'b10, 0, 1);
    end
    // Early release by master 1: three enable cycles, then master 3.
    add(0, 4'b0010, 4'b0010, 2'b01, 1, 1);
    add(0, 4'b0010, 4'b0010, 2'b01, 1, 1);
    add(0, 4'b0010, 4'b0010, 2'b01, 1, 1);
    add(0, 4'b1000, 4'b0000, 2'b01, 0, 1);
    for (int k = 0; k < 4; k++) add(0, 4'b1000, 4'b1000, 2'b11, 1, 1);
    // Contention 0101 after master 3: wrap to master 0, then master 2.
    add(0, 4'b0101, 4'b0000, 2'b11, 0, 1);
    for (int k = 0; k < 4; k++) add(0, 4'b0101, 4'b0001, 2'b00, 1, 1);
    add(0, 4'b0101, 4'b0000, 2'b00, 0, 1);
    add(0, 4'b0101, 4'b0100, 2'b10, 1, 1);
    add(0, 4'b0101, 4'b0100, 2'b10, 1, 1);
    // Reset during master 2's tenure, then 0110 goes to master 1.
    add(1, 4'b0101, 4'b0000, 2'b00, 0, 0);
    add(0, 4'b0110, 4'b0010, 2'b01, 1, 1);
    add(0, 4'b0000, 4'b0000, 2'b01, 0, 1);
    add(0, 4'b0000, 4'b0000, 2'b01, 0, 0);   // idle keeps last s

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      rst4 = tv[i].rst;
      req4 = tv[i].req;
      @(posedge clk);
      #1;
      row   = i;
      s_act = s4;
      chk("grant4",  32'(grant4), 32'(tv[i].grant));
      chk("s4",      32'(s_act),  32'(tv[i].s));
      chk("enable4", 32'(en4),    32'(tv[i].en));
      chk("busy4",   32'(busy4),  32'(tv[i].busy));
    end

    // Round-robin at MAX_BURST=2: owners 0,1,2,3,0 each 2 cycles, 1 dead cycle between.
    @(negedge clk);
    rst2 = 1'b1; req2 = 4'b1111;
    @(posedge clk);
    #1;
    row = 1000;
    chk("rr_reset_enable", 32'(en2), 32'd0);
    chk("rr_reset_grant",  32'(grant2), 32'd0);
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      rst2 = 1'b0; req2 = 4'b1111;
      @(posedge clk);
      #1;
      row   = 1001 + t;
      owner = (t / 3) % 4;
      phase = t % 3;
      g_exp = (phase < 2) ? (4'b0001 << owner) : 4'b0000;
      s_act = s2;
      chk("rr_grant",  32'(grant2), 32'(g_exp));
      chk("rr_s",      32'(s_act),  32'(owner));
      chk("rr_enable", 32'(en2),    32'(phase < 2));
      chk("rr_busy",   32'(busy2),  32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
